snake_engine: RTL and testbench

// Parametrised snake body engine: stores up to MAX_LEN segment positions in cell coordinates,

---
 rtl/snake_pkg.sv | 34 +++
 rtl/snake_cell_painter.sv | 37 +++
 rtl/snake_engine.sv | 246 ++++++++++++++++++++++++
 tb/tb_snake_engine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and defaults for the snake body engine.
//   dir_t    : movement direction, 0=R 1=D 2=U 3=L
//   opposite : the 180-degree reversal of a direction
//   state_t  : engine FSM encoding
//   colour defaults for body and background pixels
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_R = 2'd0,
        DIR_D = 2'd1,
        DIR_U = 2'd2,
        DIR_L = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAINT_ALL,
        S_MOVE,
        S_CHECK,
        S_ERASE,
        S_SHIFT,
        S_DRAW,
        S_DEAD
    } state_t;

    localparam logic [2:0] BODY_COLOUR_DEF = 3'b010;
    localparam logic [2:0] BG_COLOUR_DEF   = 3'b000;

    // The encoding pairs R/L as 0/3 and D/U as 1/2, so the reversal is a bit flip.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(~d);
    endfunction

endpackage

// File: rtl/snake_cell_painter.sv
// CELL x CELL raster counter used to walk the pixels of one cell.
//   CLOCK_50 : clock
//   Resetn   : synchronous active-low reset
//   load     : return the raster position to (0,0)
//   en       : advance one pixel (xc inner, yc outer); wraps to (0,0) after the last pixel
//   xc, yc   : pixel offset inside the cell
//   last     : current pixel is the final one of the cell
module snake_cell_painter #(
    parameter int CELL = 10,
    parameter int PW   = (CELL > 1) ? $clog2(CELL) : 1
) (
    input  logic          CLOCK_50,
    input  logic          Resetn,
    input  logic          load,
    input  logic          en,
    output logic [PW-1:0] xc,
    output logic [PW-1:0] yc,
    output logic          last
);

    assign last = (xc == PW'(CELL - 1)) && (yc == PW'(CELL - 1));

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn || load) begin
            xc <= '0;
            yc <= '0;
        end else if (en) begin
            if (xc == PW'(CELL - 1)) begin
                xc <= '0;
                yc <= last ? '0 : yc + 1'b1;
            end else begin
                xc <= xc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_engine.sv
// Snake body engine: keeps up to MAX_LEN segment cells, advances one cell per
// accepted tick, grows on request, detects wall/self collision and drives
// vga_adapter pixel writes (erase old tail, paint new head).
//   CLOCK_50, Resetn        : clock, synchronous active-low reset
//   start                   : reload initial body and paint it; also leaves DEAD
//   tick, grow              : advance one cell (IDLE only); grow sampled with tick
//   dir_req, dir_valid      : requested direction (0=R 1=D 2=U 3=L)
//   busy, done, dead        : status; done pulses once per completed move/paint
//   length, head_x, head_y  : current body length and head cell
//   vga_x, vga_y, vga_colour, plot : one pixel write per cycle while painting
module snake_engine
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 4,
    parameter int CELL     = 10,
    parameter int GRID_W   = 16,
    parameter int GRID_H   = 12,
    parameter int CW       = 4,
    parameter int CH       = 4,
    parameter int LW       = 5,
    parameter int HEAD_X0  = 8,
    parameter int HEAD_Y0  = 6,
    parameter int WRAP     = 0,
    parameter logic [2:0] BODY_COLOUR = BODY_COLOUR_DEF,
    parameter logic [2:0] BG_COLOUR   = BG_COLOUR_DEF
) (
    input  logic          CLOCK_50,
    input  logic          Resetn,
    input  logic          start,
    input  logic          tick,
    input  logic [1:0]    dir_req,
    input  logic          dir_valid,
    input  logic          grow,
    output logic          busy,
    output logic          done,
    output logic          dead,
    output logic [LW-1:0] length,
    output logic [CW-1:0] head_x,
    output logic [CH-1:0] head_y,
    output logic [7:0]    vga_x,
    output logic [6:0]    vga_y,
    output logic [2:0]    vga_colour,
    output logic          plot
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int PW = (CELL > 1) ? $clog2(CELL) : 1;

    state_t        state, state_n;
    dir_t          dir, pending;
    logic          grow_r;
    logic [LW-1:0] len_r;
    logic [LW-1:0] idx;
    logic          done_r;
    logic [CW-1:0] seg_x [MAX_LEN];
    logic [CH-1:0] seg_y [MAX_LEN];
    logic [CW-1:0] nh_x, cand_x, cell_x;
    logic [CH-1:0] nh_y, cand_y, cell_y;
    logic          wall;

    // FSM strobes into the datapath
    logic reload, accept, latch_nh, idx_clr, idx_inc, do_shift, done_set;

    logic [PW-1:0] xc, yc;
    logic          last, pix_on;

    logic [LW-1:0] len_m1;
    logic [IW-1:0] idx_a, tail_a;
    logic          last_seg, hit;

    assign len_m1   = len_r - 1'b1;
    assign idx_a    = idx[IW-1:0];
    assign tail_a   = len_m1[IW-1:0];
    assign last_seg = (idx == len_m1);
    // The tail cell is vacated by this move unless the snake is growing.
    assign hit      = (nh_x == seg_x[idx_a]) && (nh_y == seg_y[idx_a]) && (!last_seg || grow_r);

    // Candidate head: edge tested on the untruncated coordinate, wrapped value
    // is only used when WRAP=1 (otherwise the wall flag kills the snake).
    always_comb begin
        cand_x = seg_x[0];
        cand_y = seg_y[0];
        wall   = 1'b0;
        case (dir)
            DIR_R: if (seg_x[0] == CW'(GRID_W - 1)) begin wall = 1'b1; cand_x = '0; end
                   else cand_x = seg_x[0] + 1'b1;
            DIR_L: if (seg_x[0] == '0) begin wall = 1'b1; cand_x = CW'(GRID_W - 1); end
                   else cand_x = seg_x[0] - 1'b1;
            DIR_D: if (seg_y[0] == CH'(GRID_H - 1)) begin wall = 1'b1; cand_y = '0; end
                   else cand_y = seg_y[0] + 1'b1;
            DIR_U: if (seg_y[0] == '0) begin wall = 1'b1; cand_y = CH'(GRID_H - 1); end
                   else cand_y = seg_y[0] - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) state <= S_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n  = state;
        reload   = 1'b0;
        accept   = 1'b0;
        latch_nh = 1'b0;
        idx_clr  = 1'b0;
        idx_inc  = 1'b0;
        do_shift = 1'b0;
        done_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    reload  = 1'b1;
                    state_n = S_PAINT_ALL;
                end else if (tick) begin
                    accept  = 1'b1;
                    state_n = S_MOVE;
                end
            end
            S_PAINT_ALL: begin
                if (last) begin
                    if (last_seg) begin
                        state_n  = S_IDLE;
                        done_set = 1'b1;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            S_MOVE: begin
                latch_nh = 1'b1;
                idx_clr  = 1'b1;
                state_n  = (wall && WRAP == 0) ? S_DEAD : S_CHECK;
            end
            S_CHECK: begin
                if (hit)           state_n = S_DEAD;
                else if (last_seg) state_n = grow_r ? S_SHIFT : S_ERASE;
                else               idx_inc = 1'b1;
            end
            S_ERASE: if (last) state_n = S_SHIFT;
            S_SHIFT: begin
                do_shift = 1'b1;
                state_n  = S_DRAW;
            end
            S_DRAW: begin
                if (last) begin
                    state_n  = S_IDLE;
                    done_set = 1'b1;
                end
            end
            S_DEAD: begin
                if (start) begin
                    reload  = 1'b1;
                    state_n = S_PAINT_ALL;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Reset and start share one load path: straight body facing right.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn || reload) begin
            len_r   <= LW'(INIT_LEN);
            dir     <= DIR_R;
            pending <= DIR_R;
            grow_r  <= 1'b0;
            idx     <= '0;
            nh_x    <= '0;
            nh_y    <= '0;
            done_r  <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= CW'(HEAD_X0 - i);
                seg_y[i] <= CH'(HEAD_Y0);
            end
        end else begin
            done_r <= done_set;
            if (dir_valid && dir_req != opposite(dir))
                pending <= dir_t'(dir_req);
            if (accept) begin
                dir    <= pending;
                grow_r <= grow && (len_r != LW'(MAX_LEN));
            end
            if (latch_nh) begin
                nh_x <= cand_x;
                nh_y <= cand_y;
            end
            if (idx_clr)      idx <= '0;
            else if (idx_inc) idx <= idx + 1'b1;
            if (do_shift) begin
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
                seg_x[0] <= nh_x;
                seg_y[0] <= nh_y;
                if (grow_r) len_r <= len_r + 1'b1;
            end
        end
    end

    assign pix_on = (state == S_PAINT_ALL) || (state == S_ERASE) || (state == S_DRAW);

    // Counter idles at (0,0) outside pixel states so every cell starts clean.
    snake_cell_painter #(.CELL(CELL), .PW(PW)) u_painter (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .load     (!pix_on),
        .en       (pix_on),
        .xc       (xc),
        .yc       (yc),
        .last     (last)
    );

    always_comb begin
        cell_x = seg_x[0];
        cell_y = seg_y[0];
        case (state)
            S_PAINT_ALL: begin cell_x = seg_x[idx_a];  cell_y = seg_y[idx_a];  end
            S_ERASE:     begin cell_x = seg_x[tail_a]; cell_y = seg_y[tail_a]; end
            default: ;
        endcase
    end

    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = BG_COLOUR;
        if (pix_on) begin
            vga_x = 8'(cell_x) * 8'(CELL) + 8'(xc);
            vga_y = 7'(cell_y) * 7'(CELL) + 7'(yc);
            if (state != S_ERASE) vga_colour = BODY_COLOUR;
        end
    end

    assign plot   = pix_on;
    assign busy   = (state != S_IDLE) && (state != S_DEAD);
    assign dead   = (state == S_DEAD);
    assign done   = done_r;
    assign length = len_r;
    assign head_x = seg_x[0];
    assign head_y = seg_y[0];

endmodule

// File: tb/tb_snake_engine.sv
// Scoreboard bench for snake_engine (MAX_LEN=6 so saturation is reachable).
// Stimulus pushes expected cells and expected move results; the monitor pops
// and compares as plots and done pulses appear.
module tb_snake_engine;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn = 1'b0, start = 1'b0, tick = 1'b0, grow = 1'b0, dir_valid = 1'b0;
    logic [1:0] dir_req = 2'd0;
    logic       busy, done, dead, plot;
    logic [4:0] length;
    logic [3:0] head_x, head_y;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    localparam int BODY = 2, BG = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    snake_engine #(.MAX_LEN(6)) dut (
        .CLOCK_50(CLOCK_50), .Resetn(Resetn), .start(start), .tick(tick),
        .dir_req(dir_req), .dir_valid(dir_valid), .grow(grow),
        .busy(busy), .done(done), .dead(dead), .length(length),
        .head_x(head_x), .head_y(head_y), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .plot(plot)
    );

    typedef struct { int cx; int cy; int col; } cell_t;
    typedef struct { int busy; int len; int hx; int hy; } op_t;

    cell_t cell_q[$];
    op_t   op_q[$];
    int    checks = 0, failures = 0;
    int    plot_total = 0;
    int    pix_k = 0;
    bit    mon_en = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: one comparison per 100-pixel cell and one per done pulse.
    initial begin : monitor
        int    busy_cnt;
        bit    bad;
        int    ex, ey, ax, ay, ac, bk;
        cell_t cur;
        op_t   e;
        busy_cnt = 0; bad = 0; ax = 0; ay = 0; ac = 0; bk = 0;
        cur = '{-1, -1, -1};
        forever begin
            @(negedge CLOCK_50);
            if (!mon_en || !Resetn) begin
                pix_k = 0; busy_cnt = 0; bad = 0;
                continue;
            end
            if (dead)      busy_cnt = 0;
            else if (busy) busy_cnt++;
            if (plot) begin
                plot_total++;
                if (pix_k == 0) begin
                    bad = 0;
                    if (cell_q.size() == 0) begin
                        cur = '{-1, -1, -1};
                        bad = 1; ax = vga_x; ay = vga_y; ac = vga_colour; bk = 0;
                    end else begin
                        cur = cell_q.pop_front();
                    end
                end
                ex = cur.cx * 10 + pix_k % 10;
                ey = cur.cy * 10 + pix_k / 10;
                if (!bad && (vga_x != ex || vga_y != ey || vga_colour != cur.col)) begin
                    bad = 1; ax = vga_x; ay = vga_y; ac = vga_colour; bk = pix_k;
                end
                pix_k++;
                if (pix_k == 100) begin
                    checks++;
                    if (bad) begin
                        failures++;
                        $display("FAIL cell(%0d,%0d): pixel %0d got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                                 cur.cx, cur.cy, bk, ax, ay, ac,
                                 cur.cx * 10 + bk % 10, cur.cy * 10 + bk / 10, cur.col);
                    end
                    pix_k = 0;
                end
            end
            if (done) begin
                checks++;
                if (op_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: got done with len=%0d expected no done", length);
                end else begin
                    e = op_q.pop_front();
                    if (busy_cnt != e.busy || length != e.len || head_x != e.hx || head_y != e.hy) begin
                        failures++;
                        $display("FAIL op: got busy=%0d len=%0d head=(%0d,%0d) expected busy=%0d len=%0d head=(%0d,%0d)",
                                 busy_cnt, length, head_x, head_y, e.busy, e.len, e.hx, e.hy);
                    end
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic pulse_start();
        @(posedge CLOCK_50); #1 start = 1'b1;
        @(posedge CLOCK_50); #1 start = 1'b0;
    endtask

    task automatic do_tick(input bit g);
        @(posedge CLOCK_50); #1 tick = 1'b1; grow = g;
        @(posedge CLOCK_50); #1 tick = 1'b0; grow = 1'b0;
    endtask

    task automatic set_dir(input int d);
        @(posedge CLOCK_50); #1 dir_req = 2'(d); dir_valid = 1'b1;
        @(posedge CLOCK_50); #1 dir_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin @(negedge CLOCK_50); n++; end while (!done && n < 3000);
        if (!done) begin
            checks++; failures++;
            $display("FAIL timeout_%s: got no done in %0d cycles expected done", name, n);
        end
    endtask

    // Counts busy cycles between an accepted tick and the DEAD state.
    task automatic wait_dead(input string name, input int exp_busy);
        int n, k;
        n = 0; k = 0;
        while (!dead && k < 50) begin
            @(negedge CLOCK_50);
            k++;
            if (!dead && busy) n++;
        end
        chk({name, "_dead"}, dead, 1);
        chk({name, "_busy_cycles"}, n, exp_busy);
    endtask

    task automatic exp_paint4();
        cell_q.push_back('{8, 6, BODY});
        cell_q.push_back('{7, 6, BODY});
        cell_q.push_back('{6, 6, BODY});
        cell_q.push_back('{5, 6, BODY});
        op_q.push_back('{400, 4, 8, 6});
    endtask

    task automatic exp_move(input int tx, input int ty, input int hx, input int hy,
                            input bit g, input int len_b, input int len_a);
        if (!g) cell_q.push_back('{tx, ty, BG});
        cell_q.push_back('{hx, hy, BODY});
        op_q.push_back('{1 + len_b + (g ? 0 : 100) + 1 + 100, len_a, hx, hy});
    endtask

    initial begin : stim
        int snap;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dead", dead, 0);
        chk("rst_plot", plot, 0);
        chk("rst_length", length, 4);
        chk("rst_head_x", head_x, 8);
        chk("rst_head_y", head_y, 6);
        chk("rst_vga_x", vga_x, 0);
        chk("rst_vga_y", vga_y, 0);
        chk("rst_colour", vga_colour, BG);
        @(posedge CLOCK_50); #1 Resetn = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        chk("no_paint_before_start", plot_total, 0);

        exp_paint4(); pulse_start(); wait_done("start");

        // plain move right; stray tick and start mid-move must be ignored
        exp_move(5, 6, 9, 6, 0, 4, 4); do_tick(0);
        repeat (20) @(posedge CLOCK_50);
        #1 tick = 1'b1; start = 1'b1;
        @(posedge CLOCK_50); #1 tick = 1'b0; start = 1'b0;
        wait_done("move_r");

        set_dir(3);  // reversal of R: discarded
        exp_move(6, 6, 10, 6, 0, 4, 4); do_tick(0); wait_done("reverse_discard");
        set_dir(1);
        exp_move(7, 6, 10, 7, 0, 4, 4); do_tick(0); wait_done("turn_down");
        set_dir(3);
        exp_move(8, 6, 9, 7, 0, 4, 4);  do_tick(0); wait_done("turn_left");
        // head steps onto the cell the tail is leaving
        set_dir(2);
        exp_move(9, 6, 9, 6, 0, 4, 4);  do_tick(0); wait_done("chase_tail_up");
        set_dir(0);
        exp_move(10, 6, 10, 6, 0, 4, 4); do_tick(0); wait_done("chase_tail_right");

        exp_move(0, 0, 11, 6, 1, 4, 5); do_tick(1); wait_done("grow_5");
        exp_move(0, 0, 12, 6, 1, 5, 6); do_tick(1); wait_done("grow_6");
        exp_move(10, 7, 13, 6, 0, 6, 6); do_tick(1); wait_done("grow_at_max");
        exp_move(9, 7, 14, 6, 0, 6, 6); do_tick(0); wait_done("move_14");
        exp_move(9, 6, 15, 6, 0, 6, 6); do_tick(0); wait_done("move_15");

        // wall at x=15 moving right
        snap = plot_total;
        do_tick(0);
        wait_dead("wall", 1);
        do_tick(0); do_tick(0);
        repeat (20) @(negedge CLOCK_50);
        chk("wall_still_dead", dead, 1);
        chk("wall_head_x", head_x, 15);
        chk("wall_length", length, 6);
        chk("wall_no_plots", plot_total - snap, 0);

        // restart from DEAD, then length-5 loop R,D,L,U into own body
        exp_paint4(); pulse_start(); wait_done("restart");
        chk("restart_dead_clear", dead, 0);
        exp_move(0, 0, 9, 6, 1, 4, 5); do_tick(1); wait_done("loop_grow_r");
        set_dir(1);
        exp_move(5, 6, 9, 7, 0, 5, 5); do_tick(0); wait_done("loop_d");
        set_dir(3);
        exp_move(6, 6, 8, 7, 0, 5, 5); do_tick(0); wait_done("loop_l");
        set_dir(2);
        snap = plot_total;
        do_tick(0);
        wait_dead("self_hit", 5);
        chk("self_hit_length", length, 5);
        chk("self_hit_head_y", head_y, 7);
        repeat (5) @(negedge CLOCK_50);
        chk("self_hit_no_plots", plot_total - snap, 0);

        chk("cells_drained", cell_q.size(), 0);
        chk("ops_drained", op_q.size(), 0);
        chk("no_partial_cell", pix_k, 0);

        // reset in the middle of a paint
        mon_en = 1'b0;
        pulse_start();
        repeat (50) @(posedge CLOCK_50);
        #1 Resetn = 1'b0;
        @(negedge CLOCK_50);
        chk("painting_before_reset", plot, 1);
        @(negedge CLOCK_50);
        chk("midrst_plot", plot, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_dead", dead, 0);
        chk("midrst_length", length, 4);
        chk("midrst_head_x", head_x, 8);
        @(posedge CLOCK_50); #1 Resetn = 1'b1;
        mon_en = 1'b1;
        exp_paint4(); pulse_start(); wait_done("after_reset");

        repeat (5) @(negedge CLOCK_50);
        chk("final_cells_drained", cell_q.size(), 0);
        chk("final_ops_drained", op_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before 2000000 time units");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
